// File: rtl/bsa_pkg.sv
// Shared types and constants for the byte-serial wide adder.
package bsa_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned NBYTES_MIN = 1;
  localparam int unsigned NBYTES_MAX = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } bsa_state_e;

endpackage

// File: rtl/byte_serial_adder32_cla8.sv
// 8-bit carry-lookahead adder (CLA_Adder8); purely combinational.
module byte_serial_adder32_cla8
  import bsa_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              cin_i,
  output logic [BYTE_W-1:0] sum_o,
  output logic              cout_o
);

  logic [BYTE_W-1:0] gen;
  logic [BYTE_W-1:0] prop;
  logic [BYTE_W:0]   carry;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // Each carry is built independently from g/p terms so no carry feeds another.
  always_comb begin
    logic c_term;
    carry = '0;
    for (int i = 0; i <= BYTE_W; i++) begin
      c_term = cin_i;
      for (int j = 0; j < i; j++) begin
        c_term = gen[j] | (prop[j] & c_term);
      end
      carry[i] = c_term;
    end
  end

  assign sum_o  = prop ^ carry[BYTE_W-1:0];
  assign cout_o = carry[BYTE_W];

endmodule

// File: rtl/byte_serial_adder32.sv
// Byte-serial wide adder feeding one 8-bit CLA, LSB first.
// Optional subtract port enabled by defining BSA_SUB_EN.
module byte_serial_adder32
  import bsa_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
`ifdef BSA_SUB_EN
  input  logic                     sub,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout
);

  localparam int unsigned W    = BYTE_W * NBYTES;
  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned OffW = IdxW + 3;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NBYTES - 1);

  if (NBYTES < NBYTES_MIN || NBYTES > NBYTES_MAX) begin : gen_bad_nbytes
    $error("byte_serial_adder32: NBYTES out of range");
  end

  bsa_state_e        state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              cout_q, cout_d;

  logic [OffW-1:0]   lane_lsb;
  logic [BYTE_W-1:0] add_sum;
  logic              add_cout;
  logic [W-1:0]      b_capture;
  logic              cin_capture;

  assign lane_lsb = {idx_q, 3'b000};

`ifdef BSA_SUB_EN
  assign b_capture   = sub ? ~b : b;
  assign cin_capture = sub | cin;
`else
  assign b_capture   = b;
  assign cin_capture = cin;
`endif

  byte_serial_adder32_cla8 u_cla_adder8 (
    .a_i    (a_q[lane_lsb +: BYTE_W]),
    .b_i    (b_q[lane_lsb +: BYTE_W]),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          a_d     = a;
          b_d     = b_capture;
          carry_d = cin_capture;
          idx_d   = '0;
        end
      end
      StRun: begin
        sum_d[lane_lsb +: BYTE_W] = add_sum;
        carry_d                   = add_cout;
        if (idx_q == IdxLast) begin
          state_d = StDone;
          cout_d  = add_cout;
          // Parked at zero so idx never leaves 0..NBYTES-1.
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
